// File: rtl/dma_engine.sv
// Memory-to-memory copy engine for dma_wrapper_m.
// A copy of i_len words is split into bursts of up to BURST_MAX beats. Each burst is read
// into a local FIFO, then written back out. Only one burst is in flight at a time.
module dma_engine #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LEN_W     = 4,
  parameter int unsigned BURST_MAX = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  // control register side
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_src_addr,
  input  logic [ADDR_W-1:0] i_dst_addr,
  input  logic [CNT_W-1:0]  i_len,
  output logic              o_busy,
  output logic              o_done,
  // read burst side
  output logic              o_DMA_READ,
  output logic [ADDR_W-1:0] o_DMA_ARADDR,
  output logic [LEN_W-1:0]  o_DMA_ARLEN,
  input  logic              i_DMA_RNEW,
  input  logic [DATA_W-1:0] i_DMA_RDATA,
  // write burst side
  output logic              o_DMA_WRITE,
  output logic [ADDR_W-1:0] o_DMA_AWADDR,
  output logic [LEN_W-1:0]  o_DMA_AWLEN,
  output logic              o_DMA_WNEW,
  output logic [DATA_W-1:0] o_DMA_WDATA,
  output logic              o_DMA_WLAST,
  input  logic              i_W_HS,
  input  logic              i_DMA_wr_idle
);

  // Beat counts run 0..BURST_MAX inclusive, so they need one bit more than a pointer.
  localparam int unsigned BEAT_W = $clog2(BURST_MAX + 1);
  localparam int unsigned PTR_W  = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdData,
    StWrReq,
    StWrData,
    StWrWait,
    StDone
  } state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_src;
  logic [ADDR_W-1:0]   r_dst;
  logic [CNT_W-1:0]    r_rem;
  logic [BEAT_W-1:0]   r_beats;
  logic [BEAT_W-1:0]   r_cnt;
  logic                r_read;
  logic                r_write;
  logic                r_done;

  logic [DATA_W-1:0]   r_fifo [BURST_MAX];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [BEAT_W-1:0]   r_fcnt;

  logic                w_push;
  logic                w_pop;
  logic                w_fifo_empty;
  logic                w_wnew;
  logic                w_last;
  logic [CNT_W-1:0]    w_rem_next;
  logic [ADDR_W-1:0]   w_step;
  logic [BEAT_W-1:0]   w_beats_m1;

  // Size of the next burst: min(remaining, BURST_MAX).
  function automatic logic [BEAT_W-1:0] f_beats(input logic [CNT_W-1:0] rem);
    if (rem >= CNT_W'(BURST_MAX)) begin
      return BEAT_W'(BURST_MAX);
    end
    return BEAT_W'(rem);
  endfunction

  // Circular pointer increment; depth need not be a power of two.
  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BURST_MAX - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_push       = (r_state == StRdData) && i_DMA_RNEW;
  assign w_fifo_empty = (r_fcnt == '0);
  assign w_wnew       = (r_state == StWrData) && !w_fifo_empty;
  assign w_pop        = w_wnew && i_W_HS;
  assign w_beats_m1   = r_beats - BEAT_W'(1);
  assign w_last       = (r_cnt == w_beats_m1);
  assign w_rem_next   = r_rem - CNT_W'(r_beats);
  assign w_step       = ADDR_W'({r_beats, 2'b00});

  // FIFO storage; contents need no reset because the output is gated by o_DMA_WNEW.
  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= i_DMA_RDATA;
    end
  end

  // FIFO pointers and occupancy; push and pop never coincide (different states).
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fcnt   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= f_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_inc(r_rd_ptr);
      end
      if (w_push && !w_pop) begin
        r_fcnt <= r_fcnt + BEAT_W'(1);
      end else if (w_pop && !w_push) begin
        r_fcnt <= r_fcnt - BEAT_W'(1);
      end
    end
  end

  // Copy sequencer with registered request/done pulses.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= StIdle;
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_beats <= '0;
      r_cnt   <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_src   <= i_src_addr;
            r_dst   <= i_dst_addr;
            r_rem   <= i_len;
            r_beats <= f_beats(i_len);
            r_cnt   <= '0;
            if (i_len == '0) begin
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_read  <= 1'b1;
              r_state <= StRdReq;
            end
          end
        end
        StRdReq: begin
          r_read  <= 1'b0;
          r_state <= StRdData;
        end
        StRdData: begin
          if (w_push) begin
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= StWrReq;
            end else begin
              r_cnt <= r_cnt + BEAT_W'(1);
            end
          end
        end
        StWrReq: begin
          // Request is raised once the wrapper is idle, held one cycle, then data follows.
          if (r_write) begin
            r_write <= 1'b0;
            r_state <= StWrData;
          end else if (i_DMA_wr_idle) begin
            r_write <= 1'b1;
          end
        end
        StWrData: begin
          if (w_pop) begin
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= StWrWait;
            end else begin
              r_cnt <= r_cnt + BEAT_W'(1);
            end
          end
        end
        StWrWait: begin
          // Wrapper idle again means the write response has come back.
          if (i_DMA_wr_idle) begin
            r_src   <= r_src + w_step;
            r_dst   <= r_dst + w_step;
            r_rem   <= w_rem_next;
            r_beats <= f_beats(w_rem_next);
            if (w_rem_next == '0) begin
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_read  <= 1'b1;
              r_state <= StRdReq;
            end
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_busy       = (r_state != StIdle);
  assign o_done       = r_done;

  // Address/length buses are zero outside their request pulse.
  assign o_DMA_READ   = r_read;
  assign o_DMA_ARADDR = r_read ? r_src : '0;
  assign o_DMA_ARLEN  = r_read ? LEN_W'(w_beats_m1) : '0;

  assign o_DMA_WRITE  = r_write;
  assign o_DMA_AWADDR = r_write ? r_dst : '0;
  assign o_DMA_AWLEN  = r_write ? LEN_W'(w_beats_m1) : '0;

  assign o_DMA_WNEW   = w_wnew;
  assign o_DMA_WDATA  = w_wnew ? r_fifo[r_rd_ptr] : '0;
  assign o_DMA_WLAST  = w_wnew && w_last;

endmodule

// File: tb/tb_dma_engine.sv
// Self-checking bench for dma_engine. The bench plays the wrapper: it answers read bursts
// from a sparse source memory and accepts write beats, comparing every burst request and
// every written word against the copy expected from (src, dst, len) alone.
module tb_dma_engine;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        i_start;
  logic [31:0] i_src_addr;
  logic [31:0] i_dst_addr;
  logic [15:0] i_len;
  logic        o_busy;
  logic        o_done;
  logic        o_DMA_READ;
  logic [31:0] o_DMA_ARADDR;
  logic [3:0]  o_DMA_ARLEN;
  logic        i_DMA_RNEW;
  logic [31:0] i_DMA_RDATA;
  logic        o_DMA_WRITE;
  logic [31:0] o_DMA_AWADDR;
  logic [3:0]  o_DMA_AWLEN;
  logic        o_DMA_WNEW;
  logic [31:0] o_DMA_WDATA;
  logic        o_DMA_WLAST;
  logic        i_W_HS;
  logic        i_DMA_wr_idle;

  int n_checks = 0;
  int n_errors = 0;

  // Source memory contents, created on first touch.
  logic [31:0] src_mem [logic [31:0]];

  always #5 ACLK = ~ACLK;

  dma_engine #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .LEN_W     (4),
    .BURST_MAX (16),
    .CNT_W     (16)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .i_start       (i_start),
    .i_src_addr    (i_src_addr),
    .i_dst_addr    (i_dst_addr),
    .i_len         (i_len),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_DMA_READ    (o_DMA_READ),
    .o_DMA_ARADDR  (o_DMA_ARADDR),
    .o_DMA_ARLEN   (o_DMA_ARLEN),
    .i_DMA_RNEW    (i_DMA_RNEW),
    .i_DMA_RDATA   (i_DMA_RDATA),
    .o_DMA_WRITE   (o_DMA_WRITE),
    .o_DMA_AWADDR  (o_DMA_AWADDR),
    .o_DMA_AWLEN   (o_DMA_AWLEN),
    .o_DMA_WNEW    (o_DMA_WNEW),
    .o_DMA_WDATA   (o_DMA_WDATA),
    .o_DMA_WLAST   (o_DMA_WLAST),
    .i_W_HS        (i_W_HS),
    .i_DMA_wr_idle (i_DMA_wr_idle)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge ACLK);
  endtask

  function automatic logic [31:0] src_word(input logic [31:0] a);
    if (!src_mem.exists(a)) src_mem[a] = $urandom;
    return src_mem[a];
  endfunction

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ctl"}, {o_busy, o_done, o_DMA_READ, o_DMA_WRITE, o_DMA_WNEW, o_DMA_WLAST},
              6'b0);
    check_val({tag, "_addr"}, {o_DMA_ARADDR, o_DMA_AWADDR}, 64'h0);
    check_val({tag, "_len_data"}, {o_DMA_ARLEN, o_DMA_AWLEN, o_DMA_WDATA}, 40'h0);
  endtask

  // One full copy. hs_fix<0 means random 0..2 cycle write backpressure per beat.
  // idle_hold keeps the wrapper busy that many cycles after the read burst.
  // poke issues a start while busy; abort_at>=0 resets in the middle of write beat abort_at.
  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input int hs_fix, input int idle_hold, input bit poke,
                          input int abort_at);
    logic [31:0] s, d, araddr, held;
    int rem, beats, t, hs_d;
    s = src;
    d = dst;
    rem = len;
    i_src_addr = src;
    i_dst_addr = dst;
    i_len = 16'(len);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check_val("busy_after_start", o_busy, 1);
    if (len == 0) begin
      check_val("done_len0", o_done, 1);
      check_val("no_rw_len0", {o_DMA_READ, o_DMA_WRITE}, 0);
      tick();
      check_val("done_pulse_len0", o_done, 0);
      check_val("idle_len0", o_busy, 0);
      return;
    end
    while (rem > 0) begin
      beats = (rem > 16) ? 16 : rem;
      t = 0;
      while (!o_DMA_READ && t < 40) begin tick(); t++; end
      check_val("rd_req", o_DMA_READ, 1);
      if (!o_DMA_READ) return;
      check_val("araddr", o_DMA_ARADDR, s);
      check_val("arlen", o_DMA_ARLEN, beats - 1);
      araddr = o_DMA_ARADDR;
      // Stray beat during the request cycle must not reach the FIFO.
      i_DMA_RNEW = 1'b1;
      i_DMA_RDATA = 32'hDEAD_BEEF;
      tick();
      i_DMA_RNEW = 1'b0;
      check_val("rd_req_pulse", o_DMA_READ, 0);
      for (int i = 0; i < beats; i++) begin
        // Stray write handshakes while reading must not pop the FIFO.
        repeat ($urandom_range(0, 2)) begin i_W_HS = 1'($urandom_range(0, 1)); tick(); end
        i_W_HS = 1'b0;
        if (poke && i == 0) begin
          i_start = 1'b1;
          i_src_addr = 32'h5555_0000;
          i_dst_addr = 32'h6666_0000;
          i_len = 16'd3;
        end
        i_DMA_RNEW = 1'b1;
        i_DMA_RDATA = src_word(araddr + 32'(4 * i));
        tick();
        i_DMA_RNEW = 1'b0;
        i_start = 1'b0;
      end
      if (idle_hold > 0) begin
        i_DMA_wr_idle = 1'b0;
        for (int k = 0; k < idle_hold; k++) begin
          check_val("wr_held_off", o_DMA_WRITE, 0);
          tick();
        end
        check_val("wr_held_off_end", o_DMA_WRITE, 0);
        i_DMA_wr_idle = 1'b1;
      end
      t = 0;
      while (!o_DMA_WRITE && t < 40) begin tick(); t++; end
      check_val("wr_req", o_DMA_WRITE, 1);
      if (!o_DMA_WRITE) return;
      check_val("awaddr", o_DMA_AWADDR, d);
      check_val("awlen", o_DMA_AWLEN, beats - 1);
      i_DMA_wr_idle = 1'b0;
      tick();
      check_val("wr_req_pulse", o_DMA_WRITE, 0);
      for (int i = 0; i < beats; i++) begin
        t = 0;
        while (!o_DMA_WNEW && t < 10) begin tick(); t++; end
        check_val("wnew", o_DMA_WNEW, 1);
        if (!o_DMA_WNEW) return;
        held = o_DMA_WDATA;
        hs_d = (hs_fix >= 0) ? hs_fix : int'($urandom_range(0, 2));
        for (int k = 0; k < hs_d; k++) begin
          tick();
          check_val("wnew_hold", o_DMA_WNEW, 1);
          check_val("wdata_hold", o_DMA_WDATA, held);
        end
        if (abort_at == i) begin
          ARESET = 1'b1;
          #1;
          check_all_zero("abort");
          tick();
          check_all_zero("abort_held");
          ARESET = 1'b0;
          i_DMA_wr_idle = 1'b1;
          tick();
          check_val("abort_no_done", o_done, 0);
          return;
        end
        check_val("wdata", o_DMA_WDATA, src_word(s + 32'(4 * i)));
        check_val("wlast", o_DMA_WLAST, (i == beats - 1));
        i_W_HS = 1'b1;
        tick();
        i_W_HS = 1'b0;
      end
      check_val("wnew_after_burst", o_DMA_WNEW, 0);
      repeat ($urandom_range(1, 3)) begin
        tick();
        check_val("busy_wr_wait", {o_busy, o_done, o_DMA_READ}, 3'b100);
      end
      i_DMA_wr_idle = 1'b1;
      s = s + 32'(4 * beats);
      d = d + 32'(4 * beats);
      rem = rem - beats;
    end
    t = 0;
    while (!o_done && t < 10) begin tick(); t++; end
    check_val("done", o_done, 1);
    tick();
    check_val("done_pulse", o_done, 0);
    check_val("idle_after_done", o_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rs, rd;
    ARESET = 1'b1;
    i_start = 1'b0;
    i_src_addr = '0;
    i_dst_addr = '0;
    i_len = '0;
    i_DMA_RNEW = 1'b0;
    i_DMA_RDATA = '0;
    i_W_HS = 1'b0;
    i_DMA_wr_idle = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    ARESET = 1'b0;
    tick();
    check_val("idle_after_reset", o_busy, 0);

    // Single word with a known pattern.
    src_mem[32'h100] = 32'hA5A5_A5A5;
    run_copy(32'h100, 32'h200, 1, 0, 0, 1'b0, -1);
    // Zero length.
    run_copy(32'h300, 32'h400, 0, 0, 0, 1'b0, -1);
    // Full burst plus a short tail.
    run_copy(32'h1000, 32'h8000, 20, 0, 0, 1'b0, -1);
    // Write backpressure of 3 cycles per beat.
    run_copy(32'h2000, 32'h3000, 6, 3, 0, 1'b0, -1);
    // Wrapper write side busy for 5 cycles before the write request.
    run_copy(32'h4000, 32'h5000, 3, -1, 5, 1'b0, -1);
    // Start while busy is ignored.
    run_copy(32'h6000, 32'h7000, 18, -1, 0, 1'b1, -1);
    // Reset in the middle of the write phase, then a fresh copy.
    run_copy(32'h9000, 32'hA000, 8, 1, 0, 1'b0, 2);
    check_val("idle_after_abort", o_busy, 0);
    run_copy(32'hB000, 32'hC000, 5, -1, 0, 1'b0, -1);
    // Address wrap at the top of the address space.
    run_copy(32'hFFFF_FFC0, 32'hFFFF_FF80, 24, -1, 1, 1'b0, -1);
    // Randomized copies.
    for (int n = 0; n < 10; n++) begin
      rs = $urandom;
      rd = $urandom;
      run_copy({rs[31:2], 2'b00}, {rd[31:2], 2'b00}, int'($urandom_range(0, 40)), -1,
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
